// File: rtl/spi_freq_receiver_if.sv
// Serial-side pins and frame-word outputs of the SPI frequency-count receiver.
// Signal names follow the transmitter's pin names.
interface spi_freq_receiver_if #(
   parameter int WIDTH = 32
);
   logic             SCK;
   logic             CS;
   logic             MOSI;
   logic [WIDTH-1:0] data;
   logic             data_valid;
   logic             frame_err;
   logic             busy;
   logic [7:0]       frame_cnt;

   modport master (
      output SCK, CS, MOSI,
      input  data, data_valid, frame_err, busy, frame_cnt
   );

   modport slave (
      input  SCK, CS, MOSI,
      output data, data_valid, frame_err, busy, frame_cnt
   );
endinterface

// File: rtl/spi_freq_receiver.sv
// SPI mode-0 receiver for a WIDTH-bit frequency-count word, oversampled by clk.
//
//   state | meaning
//   IDLE  | waiting for a CS fall
//   RECV  | shifting in MOSI on each SCK rise
//   DONE  | one cycle: publish word, pulse data_valid
//   ERR   | one cycle: wrong bit count, pulse frame_err
module spi_freq_receiver #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input logic              clk,
   input logic              rst,
   spi_freq_receiver_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic                   sck_prev, cs_prev;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, cs_rise, cs_fall;
   logic                   cs_fall_pend;
   logic [1:0]             flush_cnt;
   logic                   armed;
   logic                   start;
   logic [WIDTH-1:0]       shift_reg, data_q;
   logic [CW-1:0]          bit_cnt;
   logic [7:0]             frame_cnt_q;

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = ~sck_prev & sck_s;
   assign cs_rise  = ~cs_prev & cs_s;
   assign cs_fall  = cs_prev & ~cs_s;
   // After reset the synchroniser holds idle levels, so a CS already low at release
   // would look like a fresh fall; only accept falls once real CS has been seen high.
   assign start    = armed & (cs_fall | cs_fall_pend);

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync     <= '0;
         cs_sync      <= '1;
         mosi_sync    <= '0;
         sck_prev     <= 1'b0;
         cs_prev      <= 1'b1;
         flush_cnt    <= 2'd0;
         armed        <= 1'b0;
         cs_fall_pend <= 1'b0;
      end else begin
         sck_sync     <= {sck_sync[SYNC_STAGES-2:0], bus.SCK};
         cs_sync      <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
         mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
         sck_prev     <= sck_s;
         cs_prev      <= cs_s;
         if (flush_cnt != 2'(SYNC_STAGES))
            flush_cnt <= flush_cnt + 2'd1;
         else if (cs_s)
            armed <= 1'b1;
         cs_fall_pend <= ((state_q == DONE) || (state_q == ERR)) & (cs_fall | cs_fall_pend);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RECV;
         RECV: if (cs_rise) state_d = (bit_cnt == CW'(WIDTH)) ? DONE : ERR;
         DONE: state_d = IDLE;
         ERR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // data and frame_cnt load on the RECV->DONE edge so they are current during data_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg   <= '0;
         bit_cnt     <= '0;
         data_q      <= '0;
         frame_cnt_q <= 8'd0;
      end else begin
         if (state_q == IDLE && start) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else if (state_q == RECV && !cs_rise && sck_rise) begin
            shift_reg <= {shift_reg[WIDTH-2:0], mosi_s};
            if (bit_cnt != CW'(WIDTH + 1))
               bit_cnt <= bit_cnt + CW'(1);
         end
         if (state_q == RECV && state_d == DONE) begin
            data_q      <= shift_reg;
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      bus.data       = data_q;
      bus.frame_cnt  = frame_cnt_q;
      bus.data_valid = (state_q == DONE);
      bus.frame_err  = (state_q == ERR);
      bus.busy       = (state_q == RECV) & ~cs_s;
   end
endmodule

// File: tb/tb_spi_freq_receiver.sv
// Bench for spi_freq_receiver: table of frames plus hand-built corner sequences,
// with expected pulses queued at stimulus time and matched as the DUT emits them.
module tb_spi_freq_receiver;
   localparam int WIDTH = 32;
   localparam int SYNC  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_freq_receiver_if #(.WIDTH(WIDTH)) bus ();

   spi_freq_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic [7:0]  cnt;
   } exp_t;

   typedef struct {
      logic [31:0] word;
      int          nbits;
   } vec_t;

   exp_t        sb[$];
   exp_t        e;
   int          checks   = 0;
   int          errors   = 0;
   int          n_valid  = 0;
   logic [31:0] exp_data = '0;
   logic [7:0]  exp_cnt  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (bus.data_valid || bus.frame_err)) begin
         if (bus.data_valid) n_valid++;
         if (sb.size() == 0) begin
            check("unexpected_pulse", {bus.data_valid, bus.frame_err}, 2'b00);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", {bus.data_valid, bus.frame_err}, e.valid ? 2'b10 : 2'b01);
            check("pulse_data", bus.data, e.data);
            check("pulse_frame_cnt", bus.frame_cnt, e.cnt);
         end
      end
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input bit good, input logic [31:0] word);
      exp_t x;
      if (good) begin
         exp_cnt  = exp_cnt + 8'd1;
         exp_data = word;
      end
      x.valid = good;
      x.data  = exp_data;
      x.cnt   = exp_cnt;
      sb.push_back(x);
   endtask

   task automatic shift_bits(input logic [31:0] word, input int n, input int half, input bit chk_busy);
      for (int i = 0; i < n; i++) begin
         bus.MOSI = (i < 32) ? word[31-i] : 1'b1;
         wait_clk(half);
         bus.SCK = 1'b1;
         wait_clk(half);
         bus.SCK = 1'b0;
         if (chk_busy && i == 1) check("busy_in_frame", bus.busy, 1'b1);
      end
   endtask

   task automatic cs_high(input int half, input int gap);
      wait_clk(half);
      bus.CS = 1'b1;
      wait_clk(gap);
   endtask

   task automatic frame(input logic [31:0] word, input int n, input int half, input int gap,
                        input bit chk_busy);
      bus.CS  = 1'b0;
      bus.SCK = 1'b0;
      shift_bits(word, n, half, chk_busy);
      push_exp(n == WIDTH, word);
      cs_high(half, gap);
   endtask

   vec_t        vecs[6];
   int          lat;
   int          v0;
   logic [31:0] w;

   initial begin
      vecs[0] = '{32'hA5A5_0001, 32};
      vecs[1] = '{32'h1357_9BDF, 31};
      vecs[2] = '{32'h0F0F_F0F0, 33};
      vecs[3] = '{32'hFFFF_FFFF, 32};
      vecs[4] = '{32'hDEAD_BEEF, 0};
      vecs[5] = '{32'h0000_0000, 32};

      bus.SCK  = 1'b0;
      bus.CS   = 1'b1;
      bus.MOSI = 1'b0;
      rst      = 1'b1;
      wait_clk(3);
      check("rst_data", bus.data, 32'h0);
      check("rst_data_valid", bus.data_valid, 1'b0);
      check("rst_frame_err", bus.frame_err, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_frame_cnt", bus.frame_cnt, 8'd0);
      rst = 1'b0;
      wait_clk(5);

      for (int i = 0; i < 6; i++) begin
         frame(vecs[i].word, vecs[i].nbits, 5, 10, vecs[i].nbits > 1);
         check("idle_busy", bus.busy, 1'b0);
      end

      // data_valid latency from the CS rise at the pin
      bus.CS = 1'b0;
      shift_bits(32'hC3C3_0F0F, 32, 5, 0);
      push_exp(1'b1, 32'hC3C3_0F0F);
      wait_clk(5);
      bus.CS = 1'b1;
      lat = 0;
      while (lat < 20) begin
         wait_clk(1);
         lat++;
         if (bus.data_valid) break;
      end
      check("valid_latency", lat, SYNC + 1);
      wait_clk(10);

      // SCK rise coincident with CS rise after 32 good bits
      bus.CS = 1'b0;
      shift_bits(32'h0F1E_2D3C, 32, 5, 0);
      push_exp(1'b1, 32'h0F1E_2D3C);
      bus.MOSI = 1'b1;
      wait_clk(5);
      bus.SCK = 1'b1;
      bus.CS  = 1'b1;
      wait_clk(10);
      bus.SCK = 1'b0;
      wait_clk(5);

      // CS fall landing in DONE is held off, not lost
      frame(32'h2468_ACE0, 32, 5, 1, 0);
      frame(32'h8642_0BDF, 32, 5, 10, 0);

      // reset in the middle of a frame
      bus.CS  = 1'b0;
      bus.SCK = 1'b0;
      shift_bits(32'hFFFF_FFFF, 16, 5, 0);
      wait_clk(2);
      check("sb_empty_before_rst", sb.size(), 0);
      rst = 1'b1;
      wait_clk(1);
      rst      = 1'b0;
      exp_cnt  = 8'd0;
      exp_data = 32'h0;
      check("midrst_data", bus.data, 32'h0);
      check("midrst_frame_cnt", bus.frame_cnt, 8'd0);
      check("midrst_busy", bus.busy, 1'b0);
      shift_bits(32'hFFFF_FFFF, 8, 5, 0);
      cs_high(5, 10);
      frame(32'h1234_5678, 32, 5, 10, 1);
      wait_clk(5);
      check("midrst_final_data", bus.data, 32'h1234_5678);
      check("midrst_final_cnt", bus.frame_cnt, 8'd1);

      // 257 back-to-back frames, CS high 2 clk, SCK at clk/4
      rst = 1'b1;
      wait_clk(2);
      rst      = 1'b0;
      exp_cnt  = 8'd0;
      exp_data = 32'h0;
      wait_clk(5);
      v0 = n_valid;
      w  = 32'h0;
      for (int k = 0; k < 257; k++) begin
         w = $urandom;
         frame(w, 32, 2, 2, 0);
      end
      wait_clk(10);
      check("b2b_valid_pulses", n_valid - v0, 257);
      check("b2b_frame_cnt", bus.frame_cnt, 8'd1);
      check("b2b_last_data", bus.data, w);

      wait_clk(20);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_freq_receiver.md
SPI_FREQ_RECEIVER -- requirements
Module: spi_freq_receiver

Interface
REQ-001 Parameter WIDTH, default 32, frame length in bits (the frequency-count word).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth on SCK, CS and MOSI; legal range 2-3.
REQ-003 clk  input  1  system clock; single clock domain for all logic.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 SCK  input  1  serial clock from the transmitter, asynchronous to clk.
REQ-006 CS  input  1  chip select, active-low, asynchronous to clk.
REQ-007 MOSI  input  1  serial data, MSB first, asynchronous to clk.
REQ-008 data  output  WIDTH  last correctly received frame word.
REQ-009 data_valid  output  1  one-cycle pulse when data is updated.
REQ-010 frame_err  output  1  one-cycle pulse on a frame with the wrong bit count.
REQ-011 busy  output  1  high while a frame is in progress (synchronised CS low).
REQ-012 frame_cnt  output  8  count of good frames; wraps modulo 256.

Function
REQ-013 SCK, CS and MOSI each pass through SYNC_STAGES flops; all decisions use only the synchronised copies.
REQ-014 Edge detect: one extra register per synchronised line; rise = prev 0 and now 1, fall = prev 1 and now 0.
REQ-015 SPI mode 0: MOSI is sampled on a synchronised SCK rise only; SCK falls are ignored.
REQ-016 clk frequency shall be at least 4x the SCK frequency; behaviour below this ratio is undefined.
REQ-017 FSM states: IDLE, RECV, DONE, ERR.
REQ-018 IDLE -> RECV on CS fall; on entry, clear shift register and bit counter.
REQ-019 In RECV on SCK rise:
- shift_reg <= {shift_reg[WIDTH-2:0], MOSI_sync};
- bit_cnt increments, saturating at WIDTH+1.
REQ-020 RECV on CS rise: -> DONE if bit_cnt == WIDTH; otherwise -> ERR.
REQ-021 DONE lasts one cycle: data <= shift_reg, data_valid = 1, frame_cnt increments; then -> IDLE.
REQ-022 ERR lasts one cycle: frame_err = 1, data and frame_cnt unchanged; then -> IDLE.
REQ-023 Latency: data_valid asserts exactly 1 clk after the cycle in which the synchronised CS rise is detected.
REQ-024 An SCK rise in the same cycle as a CS rise is not sampled; CS rise has priority.
REQ-025 SCK edges while in IDLE, DONE or ERR are ignored.
REQ-026 A CS fall during DONE or ERR is held off and acted on in IDLE.
- Back-to-back frames need a CS-high time of at least 2 clk; no frame is lost at that spacing.
REQ-027 A zero-bit frame (CS low then high with no SCK rise) gives frame_err.
REQ-028 An over-length frame (more than WIDTH rises) gives frame_err, via the saturating counter.
REQ-029 busy = synchronised CS inverted, qualified by FSM state RECV.

Reset
REQ-030 On rst high at a clk edge:
- FSM -> IDLE;
- data = 0, data_valid = 0, frame_err = 0, busy = 0, frame_cnt = 0;
- shift register and bit counter cleared;
- synchroniser and edge registers loaded to idle levels (SCK 0, CS 1, MOSI 0).
REQ-031 rst mid-frame aborts the frame: no data_valid and no frame_err for it.
- Reception restarts only on a new CS fall after rst is released.
REQ-032 Reset has priority over every other event in the same cycle.

Verification
REQ-033 Good frame: clk 100 MHz, SCK 10 MHz, 32-bit frame 0xA5A50001 -> data = 0xA5A50001, one data_valid pulse 1 clk after the synchronised CS rise, frame_cnt = 1.
REQ-034 Short frame: 31 SCK rises, then CS high -> one frame_err pulse, data holds its previous value, frame_cnt unchanged.
REQ-035 Long frame: 33 SCK rises -> frame_err, no data_valid.
REQ-036 Reset mid-frame: rst for 1 cycle after bit 16 of 0xFFFFFFFF, then a full frame 0x12345678 -> no pulse for the aborted frame; then data = 0x12345678, frame_cnt = 1.
REQ-037 Back-to-back: 257 good frames with CS high 2 clk between them -> 257 data_valid pulses, final frame_cnt = 1 (wrap), last data correct.
REQ-038 Simultaneous SCK rise and CS rise on bit 33 of an otherwise good 32-bit frame -> the 33rd bit is ignored, data_valid asserts, no frame_err.
